key_expansion_seq: RTL and testbench
====================================

Name: key_expansion_seq

Overview:
- Sequential, parametrised AES key-schedule engine that generates the round keys for AES-128, AES-192 or AES-256, selected by parameter.
- Generates one 32-bit schedule word per clock.
- Presents each complete 128-bit round key on a valid/ready output handshake.
- Feeds the iterative cipher/decipher round datapath, replacing the fixed one-step 192-bit expansion combinational logic.

Parameters:
- KEY_BITS, 192, cipher key length: 128, 192 or 256. Any other value is an elaboration error.
- NK (derived, not overridable), KEY_BITS/32, key length in words: 4, 6 or 8.
- NR (derived), NK+6, number of rounds: 10, 12 or 14.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new expansion. Sampled only in IDLE.
- key  in  KEY_BITS  cipher key. Word 0 is key[KEY_BITS-1 -: 32]. Captured on start accept.
- rk  out  128  current round key, word 4r in rk[127:96].
- rk_idx  out  4  round index r of rk (0..NR).
- rk_valid  out  1  rk/rk_idx are valid.
- rk_ready  in  1  consumer accepts rk.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after round key NR is accepted.

Behaviour:
- Reset: state=IDLE; rk, rk_idx, rk_valid, busy, done=0; word counter i=0; rcon register=8'h01; window and key registers cleared. Reset in any state aborts the expansion; no partial done is produced.
- States: IDLE, GEN, EMIT.
- IDLE:
  - start=1 -> capture key into the NK-word window, set i=0, rcon=01, go to GEN.
  - start=0 -> stay in IDLE.
- GEN, one word w[i] registered per cycle:
  - i<NK: w[i] = key word i.
  - else temp = w[i-1].
    - If i%NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon) (01,02,04,...,80,1b,36).
    - Else if NK==8 and i%NK==4: temp = SubWord(temp).
    - w[i] = w[i-NK] ^ temp.
  - Window is a shift register holding the last NK words.
  - w[i] is appended to a 4-word assembly register; i increments.
  - After the 4th word of a group (i%4==3 in the cycle it is produced) -> EMIT.
- EMIT:
  - rk = assembled words; rk_valid=1. rk and rk_idx are held stable while rk_valid && !rk_ready.
  - No word is generated while in EMIT.
  - On rk_valid && rk_ready:
    - rk_idx < NR -> rk_idx++, go to GEN.
    - rk_idx == NR -> go to IDLE, done=1 for the next cycle; rk_valid drops.
- Timing with start accepted in cycle 0 and rk_ready tied high:
  - First rk_valid in cycle 5.
  - Round key spacing is 5 cycles.
  - done in cycle 5*(NR+1)+1: 56 for 128, 66 for 192, 76 for 256.
- start while busy is ignored; it does not restart or queue.
- Changes on key after the start is accepted are ignored.
- rk_ready while rk_valid=0 has no effect.
- Total words generated: 4*(NR+1), i.e. 44, 52 or 60. The last group is always complete.
- rk_idx stays at its final value until the next start accept, which resets it to 0.

Decomposition:
- aes_pkg holds:
  - functions nk_of(key_bits) and nr_of(key_bits);
  - xtime function (GF(2^8) doubling, poly 8'h1b);
  - RCON_INIT = 8'h01;
  - state enum type {IDLE, GEN, EMIT}.
- One sub-module instance: the existing 32-bit four-byte sbox, shared by the RotWord and plain-SubWord paths. The input is muxed, so there is only one instance.
- RotWord is the existing 1-byte left rotation, inlined as wiring.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk_idx=1 rk=a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 rk=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done in cycle 56.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - rk_idx=12 rk=e98ba06f448c773c8ecc720401002202.
  - 13 handshakes, then done.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk_idx=14 rk=fe4890d1e6188d0b046df344706c631e.
  - Exercises the i%8==4 SubWord path.
- Backpressure: rk_ready random at 30% high:
  - rk is stable while stalled.
  - The sequence of round keys is identical to the rk_ready=1 run.
  - Exactly NR+1 handshakes.
- start pulsed at rk_idx=3 mid-run:
  - Ignored; results unchanged.
  - After done, a new start with a different key produces a correct fresh schedule starting at rk_idx=0.
- reset asserted in GEN for round 5:
  - Next cycle: rk_valid=0, busy=0, done=0, rk_idx=0.
  - A subsequent start yields the correct full schedule (rcon restarted at 01).

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES key-schedule engine.
//   nk_of / nr_of : key length in words and round count for a key size
//   xtime         : GF(2^8) doubling (poly 8'h1b), used for the rcon sequence
//   gf_mul        : GF(2^8) multiply, used to build the S-box
//   sbox_byte     : AES forward S-box (multiplicative inverse + affine map)
//   RCON_INIT     : first round constant
//   state_t       : engine state encoding
package aes_pkg;

    typedef enum logic [1:0] {IDLE, GEN, EMIT} state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse computed as x^254 (x^2 * x^4 * ... * x^128); 0 maps to 0.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_sbox32.sv
// aes_sbox32: four parallel AES S-boxes on a 32-bit word (SubWord).
//   din  : input word
//   dout : each byte of din substituted through the S-box
module aes_sbox32
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign dout[8*gi +: 8] = sbox_byte(din[8*gi +: 8]);
        end
    endgenerate

endmodule

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES key schedule, one 32-bit word per clock,
// emitting each 128-bit round key on a valid/ready handshake.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start, key : start request (sampled in IDLE) and cipher key (word 0 in MSBs)
//   rk, rk_idx : current round key (word 4r in rk[127:96]) and its round index
//   rk_valid   : rk/rk_idx valid; rk_ready : consumer accepts rk
//   busy       : engine not idle; done : one-cycle pulse after key NR accepted
module key_expansion_seq
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 192
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic [127:0]        rk,
    output logic [3:0]          rk_idx,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic                busy,
    output logic                done
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [2:0] NK_TOP = 3'(NK - 1);
    localparam logic [3:0] NR_IDX = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
            $error("key_expansion_seq: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    state_t        state_reg;
    logic [5:0]    i_reg;          // schedule word index
    logic [2:0]    pos_reg;        // i mod NK, kept separately since NK=6 is not a power of two
    logic [7:0]    rcon_reg;
    logic [31:0]   win_reg [NK];   // win_reg[0] = w[i-NK], win_reg[NK-1] = w[i-1]
    logic [95:0]   asm_reg;        // first three words of the group being built
    logic [127:0]  rk_reg;
    logic [3:0]    rk_idx_reg;
    logic          rk_valid_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [31:0]   key_words [NK];
    logic [31:0]   temp;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   w_next;

    generate
        for (genvar gi = 0; gi < NK; gi++) begin : g_key_word
            assign key_words[gi] = key[KEY_BITS-1-32*gi -: 32];
        end
    endgenerate

    // One shared S-box: RotWord'd input at group start, plain input otherwise.
    aes_sbox32 u_sbox (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        temp   = win_reg[NK-1];
        sub_in = (pos_reg == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
        w_next = win_reg[0] ^ temp;
        // During the first NK words the window simply rotates, so win_reg[0]
        // is exactly key word i.
        if (i_reg < NK_W) begin
            w_next = win_reg[0];
        end else if (pos_reg == 3'd0) begin
            w_next = win_reg[0] ^ sub_out ^ {rcon_reg, 24'h000000};
        end else if ((NK == 8) && (pos_reg == 3'd4)) begin
            w_next = win_reg[0] ^ sub_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            i_reg        <= '0;
            pos_reg      <= '0;
            rcon_reg     <= RCON_INIT;
            asm_reg      <= '0;
            rk_reg       <= '0;
            rk_idx_reg   <= '0;
            rk_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            for (int k = 0; k < NK; k++) win_reg[k] <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++) win_reg[k] <= key_words[k];
                        i_reg      <= '0;
                        pos_reg    <= '0;
                        rcon_reg   <= RCON_INIT;
                        rk_idx_reg <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= GEN;
                    end
                end
                GEN: begin
                    for (int k = 0; k < NK - 1; k++) win_reg[k] <= win_reg[k+1];
                    win_reg[NK-1] <= w_next;
                    asm_reg       <= {asm_reg[63:0], w_next};
                    i_reg         <= i_reg + 6'd1;
                    pos_reg       <= (pos_reg == NK_TOP) ? 3'd0 : pos_reg + 3'd1;
                    if ((i_reg >= NK_W) && (pos_reg == 3'd0)) begin
                        rcon_reg <= xtime(rcon_reg);
                    end
                    if (i_reg[1:0] == 2'd3) begin
                        rk_reg       <= {asm_reg, w_next};
                        rk_valid_reg <= 1'b1;
                        state_reg    <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        rk_valid_reg <= 1'b0;
                        if (rk_idx_reg == NR_IDX) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            rk_idx_reg <= rk_idx_reg + 4'd1;
                            state_reg  <= GEN;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rk       = rk_reg;
    assign rk_idx   = rk_idx_reg;
    assign rk_valid = rk_valid_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq: directed checks of the AES key schedule for 128, 192
// and 256-bit keys, including backpressure, ignored mid-run start and reset.
module tb_key_expansion_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start;
    logic         ready;
    int           sel;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    logic [127:0] rk_a, rk_b, rk_c;
    logic [3:0]   idx_a, idx_b, idx_c;
    logic         valid_a, valid_b, valid_c;
    logic         busy_a, busy_b, busy_c;
    logic         done_a, done_b, done_c;

    key_expansion_seq #(.KEY_BITS(128)) dut128 (
        .clk(clk), .reset(reset), .start(start && sel == 0), .key(key128),
        .rk(rk_a), .rk_idx(idx_a), .rk_valid(valid_a), .rk_ready(ready && sel == 0),
        .busy(busy_a), .done(done_a));
    key_expansion_seq #(.KEY_BITS(192)) dut192 (
        .clk(clk), .reset(reset), .start(start && sel == 1), .key(key192),
        .rk(rk_b), .rk_idx(idx_b), .rk_valid(valid_b), .rk_ready(ready && sel == 1),
        .busy(busy_b), .done(done_b));
    key_expansion_seq #(.KEY_BITS(256)) dut256 (
        .clk(clk), .reset(reset), .start(start && sel == 2), .key(key256),
        .rk(rk_c), .rk_idx(idx_c), .rk_valid(valid_c), .rk_ready(ready && sel == 2),
        .busy(busy_c), .done(done_c));

    logic [127:0] cur_rk;
    logic [3:0]   cur_idx;
    logic         cur_valid, cur_busy, cur_done;

    always_comb begin
        cur_rk = rk_a; cur_idx = idx_a; cur_valid = valid_a; cur_busy = busy_a; cur_done = done_a;
        if (sel == 1) begin
            cur_rk = rk_b; cur_idx = idx_b; cur_valid = valid_b; cur_busy = busy_b; cur_done = done_b;
        end else if (sel == 2) begin
            cur_rk = rk_c; cur_idx = idx_c; cur_valid = valid_c; cur_busy = busy_c; cur_done = done_c;
        end
    end

    int           tests_run = 0;
    int           tests_failed = 0;
    logic [127:0] exp128 [0:10];
    logic [127:0] got_rk [0:15];
    int           hs_cnt;
    int           done_cyc;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one expansion on the selected instance. Stalled round keys of the
    // AES-128 KEY_A schedule are compared with the reference table each cycle.
    task automatic run_sched(input int nr, input int ready_pct, input bit mid_start,
                             input bit table_known);
        int c;
        bit prev_stall;
        hs_cnt   = 0;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c = 1;
        prev_stall = 1'b0;
        while (c < 400 && done_cyc < 0) begin
            ready = ($urandom_range(0, 99) < ready_pct);
            start = 1'b0;
            if (mid_start && cur_busy && (cur_idx == 4'd2 || cur_idx == 4'd3)) begin
                start  = 1'b1;
                key128 = ~KEY_A;
            end
            if (cur_valid) begin
                if (prev_stall && table_known)
                    check_eq("rk_stall", cur_rk, exp128[cur_idx]);
                if (ready) begin
                    check_eq("rk_idx_seq", 128'(cur_idx), 128'(hs_cnt));
                    got_rk[cur_idx] = cur_rk;
                    hs_cnt++;
                    $display("[TB] sel=%0d cycle=%0d rk_idx=%0d rk=%h", sel, c, cur_idx, cur_rk);
                end
                prev_stall = !ready;
            end else begin
                prev_stall = 1'b0;
            end
            if (cur_done) done_cyc = c;
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        ready = 1'b0;
        if (done_cyc < 0) check_eq("done_timeout", 128'd0, 128'd1);
        check_eq("done_one_cycle", 128'(cur_done), 128'd0);
        check_eq("busy_after_done", 128'(cur_busy), 128'd0);
        check_eq("rk_idx_hold", 128'(cur_idx), 128'(nr));
        check_eq("handshakes", 128'(hs_cnt), 128'(nr + 1));
    endtask

    task automatic check_all128(input string tag);
        for (int r = 0; r <= 10; r++)
            check_eq($sformatf("%s_r%0d", tag, r), got_rk[r], exp128[r]);
    endtask

    initial begin
        exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset  = 1'b1;
        start  = 1'b0;
        ready  = 1'b0;
        sel    = 0;
        key128 = KEY_A;
        key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_eq($sformatf("reset_rk_%0d", s), cur_rk, 128'd0);
            check_eq($sformatf("reset_idx_%0d", s), 128'(cur_idx), 128'd0);
            check_eq($sformatf("reset_valid_%0d", s), 128'(cur_valid), 128'd0);
            check_eq($sformatf("reset_busy_%0d", s), 128'(cur_busy), 128'd0);
            check_eq($sformatf("reset_done_%0d", s), 128'(cur_done), 128'd0);
        end

        // AES-128, no backpressure
        sel = 0;
        run_sched(10, 100, 1'b0, 1'b1);
        check_eq("a128_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("a128_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("a128_done_cycle", 128'(done_cyc), 128'd56);
        check_all128("a128");

        // AES-192
        sel = 1;
        run_sched(12, 100, 1'b0, 1'b0);
        check_eq("a192_r0", got_rk[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
        check_eq("a192_r12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
        check_eq("a192_done_cycle", 128'(done_cyc), 128'd66);

        // AES-256
        sel = 2;
        run_sched(14, 100, 1'b0, 1'b0);
        check_eq("a256_r0", got_rk[0], 128'h603deb1015ca71be2b73aef0857d7781);
        check_eq("a256_r1", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
        check_eq("a256_r14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
        check_eq("a256_done_cycle", 128'(done_cyc), 128'd76);

        // AES-128 with random backpressure
        sel = 0;
        for (int r = 0; r <= 15; r++) got_rk[r] = '0;
        run_sched(10, 30, 1'b0, 1'b1);
        check_all128("bp");

        // start pulsed and key changed mid-run: ignored
        for (int r = 0; r <= 15; r++) got_rk[r] = '0;
        run_sched(10, 100, 1'b1, 1'b1);
        check_all128("midstart");
        check_eq("midstart_done_cycle", 128'(done_cyc), 128'd56);

        // fresh start with a different key
        key128 = KEY_B;
        run_sched(10, 100, 1'b0, 1'b0);
        check_eq("keyb_r0", got_rk[0], KEY_B);
        check_eq("keyb_r1", got_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check_eq("keyb_r10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // reset while generating round 5
        key128 = KEY_A;
        begin
            int c;
            bit seen;
            seen = 1'b0;
            @(negedge clk);
            start = 1'b1;
            ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            c = 0;
            while (c < 100 && !seen) begin
                if (cur_valid && cur_idx == 4'd4) seen = 1'b1;
                @(posedge clk);
                @(negedge clk);
                c++;
            end
            if (!seen) check_eq("reset_gen_timeout", 128'd0, 128'd1);
            check_eq("in_gen_busy", 128'(cur_busy), 128'd1);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            ready = 1'b0;
            check_eq("abort_valid", 128'(cur_valid), 128'd0);
            check_eq("abort_busy", 128'(cur_busy), 128'd0);
            check_eq("abort_done", 128'(cur_done), 128'd0);
            check_eq("abort_idx", 128'(cur_idx), 128'd0);
        end
        for (int r = 0; r <= 15; r++) got_rk[r] = '0;
        run_sched(10, 100, 1'b0, 1'b1);
        check_all128("after_reset");
        check_eq("after_reset_done_cycle", 128'(done_cyc), 128'd56);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
